// File: rtl/biquad_tdm_if.sv
// Sample stream, coefficient-write and result bus of the time-multiplexed biquad.
// The master drives samples/coefficients; the slave (filter) returns results.
interface biquad_tdm_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CH_W   = 1
);
    logic              i_valid;
    logic              o_ready;
    logic [CH_W-1:0]   i_ch;
    logic [DATA_W-1:0] i_data;
    logic              i_flush;
    logic              i_coef_we;
    logic [CH_W-1:0]   i_coef_ch;
    logic [2:0]        i_coef_idx;
    logic [DATA_W-1:0] i_coef_data;
    logic              o_valid;
    logic [CH_W-1:0]   o_ch;
    logic [DATA_W-1:0] o_data;
    logic              o_sat;

    modport master (
        output i_valid, i_ch, i_data, i_flush, i_coef_we, i_coef_ch, i_coef_idx, i_coef_data,
        input  o_ready, o_valid, o_ch, o_data, o_sat
    );

    modport slave (
        input  i_valid, i_ch, i_data, i_flush, i_coef_we, i_coef_ch, i_coef_idx, i_coef_data,
        output o_ready, o_valid, o_ch, o_data, o_sat
    );
endinterface

// File: rtl/biquad_tdm.sv
// Biquad IIR section shared by N_CH channels through one multiply-accumulate unit.
// Each sample takes five MAC cycles plus one output cycle; per-channel coefficients and history.
module biquad_tdm #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned FRAC   = 15,
    parameter int unsigned N_CH   = 2
) (
    input logic         i_clk,
    input logic         i_rst,
    biquad_tdm_if.slave bus
);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned ACC_W  = 2 * DATA_W + 3;

    typedef logic signed [DATA_W-1:0] word_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    localparam word_t PassB0 = DATA_W'(1) << FRAC;
    localparam acc_t  RndC   = ACC_W'(1) << (FRAC - 1);
    localparam acc_t  MaxV   = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam acc_t  MinV   = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    state_e          state_q, state_d;
    word_t           coef_q [N_CH][5];
    word_t           coef_d [N_CH][5];
    word_t           x1_q [N_CH], x2_q [N_CH], y1_q [N_CH], y2_q [N_CH];
    word_t           x1_d [N_CH], x2_d [N_CH], y1_d [N_CH], y2_d [N_CH];
    // Per-sample snapshot: coefficients b0,b1,b2,a1,a2 and operands x0,x1,x2,y1,y2.
    word_t           sc_q [5], sc_d [5];
    word_t           sx_q [5], sx_d [5];
    logic [CH_W-1:0] ch_q, ch_d;
    logic [2:0]      cnt_q, cnt_d;
    acc_t            acc_q, acc_d;
    word_t           o_data_q, o_data_d;
    logic [CH_W-1:0] o_ch_q, o_ch_d;
    logic            o_sat_q, o_sat_d;

    logic                     accept, coef_wr, sat;
    logic signed [PROD_W-1:0] ext_c, ext_x, prod;
    acc_t                     acc_sum, shr;
    word_t                    y_sat;

    assign accept  = bus.i_valid && (state_q == StIdle) && !bus.i_flush
                     && (32'(bus.i_ch) < N_CH);
    assign coef_wr = bus.i_coef_we && (32'(bus.i_coef_ch) < N_CH) && (bus.i_coef_idx < 3'd5);

    always_comb begin
        ext_c   = PROD_W'(sc_q[cnt_q]);
        ext_x   = PROD_W'(sx_q[cnt_q]);
        prod    = ext_c * ext_x;
        acc_sum = (cnt_q >= 3'd3) ? acc_q - ACC_W'(prod) : acc_q + ACC_W'(prod);
        shr     = (acc_sum + RndC) >>> FRAC;
        sat     = 1'b0;
        y_sat   = word_t'(shr);
        if (shr > MaxV) begin
            y_sat = word_t'(MaxV);
            sat   = 1'b1;
        end else if (shr < MinV) begin
            y_sat = word_t'(MinV);
            sat   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (cnt_q == 3'd4) state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (bus.i_flush) state_d = StIdle;
    end

    always_comb begin
        bus.o_ready = (state_q == StIdle);
        bus.o_valid = (state_q == StOut);
        bus.o_data  = o_data_q;
        bus.o_ch    = o_ch_q;
        bus.o_sat   = o_sat_q;
    end

    always_comb begin
        coef_d   = coef_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        y1_d     = y1_q;
        y2_d     = y2_q;
        sc_d     = sc_q;
        sx_d     = sx_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        o_data_d = o_data_q;
        o_ch_d   = o_ch_q;
        o_sat_d  = o_sat_q;
        if (coef_wr) coef_d[bus.i_coef_ch][bus.i_coef_idx] = bus.i_coef_data;
        if (bus.i_flush) begin
            for (int c = 0; c < N_CH; c++) begin
                x1_d[c] = '0;
                x2_d[c] = '0;
                y1_d[c] = '0;
                y2_d[c] = '0;
            end
        end else if (state_q == StMac) begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd4) begin
                o_data_d = y_sat;
                o_ch_d   = ch_q;
                o_sat_d  = sat;
            end
        end else if (state_q == StOut) begin
            x2_d[ch_q] = x1_q[ch_q];
            x1_d[ch_q] = sx_q[0];
            y2_d[ch_q] = y1_q[ch_q];
            y1_d[ch_q] = o_data_q;
        end
        if (accept) begin
            ch_d    = bus.i_ch;
            cnt_d   = '0;
            acc_d   = '0;
            sc_d    = coef_q[bus.i_ch];
            sx_d[0] = bus.i_data;
            sx_d[1] = x1_q[bus.i_ch];
            sx_d[2] = x2_q[bus.i_ch];
            sx_d[3] = y1_q[bus.i_ch];
            sx_d[4] = y2_q[bus.i_ch];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < N_CH; c++) begin
                coef_q[c][0] <= PassB0;
                for (int k = 1; k < 5; k++) coef_q[c][k] <= '0;
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
            end
            for (int k = 0; k < 5; k++) begin
                sc_q[k] <= '0;
                sx_q[k] <= '0;
            end
            ch_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            o_data_q <= '0;
            o_ch_q   <= '0;
            o_sat_q  <= 1'b0;
        end else begin
            coef_q   <= coef_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            y1_q     <= y1_d;
            y2_q     <= y2_d;
            sc_q     <= sc_d;
            sx_q     <= sx_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            o_data_q <= o_data_d;
            o_ch_q   <= o_ch_d;
            o_sat_q  <= o_sat_d;
        end
    end
endmodule

// File: tb/tb_biquad_tdm.sv
// Directed, table-driven bench for biquad_tdm: passthrough, FIR, recursion, saturation,
// write during compute, flush and asynchronous reset.
module tb_biquad_tdm;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CH_W   = 1;

    typedef struct {
        int          op;   // 0 sample, 1 coefficient write, 2 flush
        int          ch;
        int          idx;
        logic [31:0] data;
        logic [31:0] exp;
        bit          sat;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t tbl[$];

    biquad_tdm_if #(.DATA_W(DATA_W), .CH_W(CH_W)) bus ();

    biquad_tdm #(.DATA_W(DATA_W), .FRAC(15), .N_CH(2)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic coef_write(input int ch, input int idx, input logic [31:0] data);
        @(negedge clk);
        bus.i_coef_we   = 1'b1;
        bus.i_coef_ch   = CH_W'(ch);
        bus.i_coef_idx  = 3'(idx);
        bus.i_coef_data = data;
        @(negedge clk);
        bus.i_coef_we   = 1'b0;
    endtask

    task automatic flush_pulse();
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
    endtask

    // Sends one sample and checks latency, ready-low window and the result; an optional
    // ch0 coefficient write is issued wcyc cycles after the accept edge.
    task automatic do_sample(input string nm, input int ch, input logic [31:0] x,
                             input logic [31:0] exp, input bit exp_sat,
                             input int wcyc, input int widx, input logic [31:0] wdata);
        int lat;
        bit rdy_bad;
        @(negedge clk);
        chk({nm, ".ready_before"}, 32'(bus.o_ready), 32'd1);
        bus.i_valid = 1'b1;
        bus.i_ch    = CH_W'(ch);
        bus.i_data  = x;
        lat     = 0;
        rdy_bad = 1'b0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            bus.i_valid     = 1'b0;
            bus.i_coef_we   = (k == wcyc);
            bus.i_coef_ch   = '0;
            bus.i_coef_idx  = 3'(widx);
            bus.i_coef_data = wdata;
            if (bus.o_ready) rdy_bad = 1'b1;
            if (bus.o_valid) lat = k;
        end
        bus.i_coef_we = 1'b0;
        chk({nm, ".latency"}, 32'(lat), 32'd6);
        chk({nm, ".ready_low"}, 32'(rdy_bad), 32'd0);
        chk({nm, ".data"}, bus.o_data, exp);
        chk({nm, ".ch"}, 32'(bus.o_ch), 32'(ch));
        chk({nm, ".sat"}, 32'(bus.o_sat), 32'(exp_sat));
        @(negedge clk);
        chk({nm, ".after"}, {30'd0, bus.o_valid, bus.o_ready}, 32'd1);
    endtask

    initial begin
        bit seen;
        n_pass  = 0;
        n_total = 0;
        bus.i_valid = 1'b0; bus.i_ch = '0; bus.i_data = '0; bus.i_flush = 1'b0;
        bus.i_coef_we = 1'b0; bus.i_coef_ch = '0; bus.i_coef_idx = '0; bus.i_coef_data = '0;
        rst = 1'b1;

        // Passthrough, FIR with interleaved channel, recursion, saturation, clipped history.
        tbl.push_back('{0, 0, 0, 32'd1000,       32'd1000,       1'b0});
        tbl.push_back('{0, 1, 0, 32'hFFFF_FFF9,  32'hFFFF_FFF9,  1'b0});
        tbl.push_back('{2, 0, 0, 32'd0,          32'd0,          1'b0});
        tbl.push_back('{1, 1, 0, 32'h4000,       32'd0,          1'b0});
        tbl.push_back('{1, 1, 1, 32'h4000,       32'd0,          1'b0});
        tbl.push_back('{0, 1, 0, 32'd1000,       32'd500,        1'b0});
        tbl.push_back('{0, 0, 0, 32'd55,         32'd55,         1'b0});
        tbl.push_back('{0, 1, 0, 32'd2000,       32'd1500,       1'b0});
        tbl.push_back('{2, 0, 0, 32'd0,          32'd0,          1'b0});
        tbl.push_back('{1, 0, 3, 32'hFFFF_C000,  32'd0,          1'b0});
        tbl.push_back('{0, 0, 0, 32'd32768,      32'd32768,      1'b0});
        tbl.push_back('{0, 0, 0, 32'd0,          32'd16384,      1'b0});
        tbl.push_back('{0, 0, 0, 32'd0,          32'd8192,       1'b0});
        tbl.push_back('{0, 0, 0, 32'd0,          32'd4096,       1'b0});
        tbl.push_back('{1, 0, 0, 32'h2_0000,     32'd0,          1'b0});
        tbl.push_back('{0, 0, 0, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1});
        tbl.push_back('{0, 0, 0, 32'h8000_0000,  32'h8000_0000,  1'b1});
        tbl.push_back('{1, 0, 0, 32'd0,          32'd0,          1'b0});
        tbl.push_back('{1, 0, 3, 32'hFFFF_8000,  32'd0,          1'b0});
        tbl.push_back('{0, 0, 0, 32'd0,          32'h8000_0000,  1'b0});
        tbl.push_back('{1, 0, 3, 32'd0,          32'd0,          1'b0});
        tbl.push_back('{1, 0, 0, 32'h8000,       32'd0,          1'b0});

        repeat (3) @(negedge clk);
        chk("reset.o_valid", 32'(bus.o_valid), 32'd0);
        chk("reset.o_ready", 32'(bus.o_ready), 32'd1);
        chk("reset.o_data",  bus.o_data,       32'd0);
        chk("reset.o_ch",    32'(bus.o_ch),    32'd0);
        chk("reset.o_sat",   32'(bus.o_sat),   32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                0: do_sample($sformatf("vec%0d", i), tbl[i].ch, tbl[i].data, tbl[i].exp,
                             tbl[i].sat, 0, 0, 32'd0);
                1: coef_write(tbl[i].ch, tbl[i].idx, tbl[i].data);
                default: flush_pulse();
            endcase
        end

        // Coefficient write while the sample is in flight only affects the next sample.
        do_sample("wr_mid", 0, 32'd100, 32'd100, 1'b0, 2, 0, 32'h1_0000);
        do_sample("wr_next", 0, 32'd100, 32'd200, 1'b0, 0, 0, 32'd0);

        // Flush during MAC: no result, histories cleared, coefficients kept.
        coef_write(0, 0, 32'h8000);
        coef_write(0, 3, 32'hFFFF_C000);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_ch = '0; bus.i_data = 32'd1000;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        bus.i_flush = 1'b1;
        @(negedge clk);
        bus.i_flush = 1'b0;
        chk("flush.ready", 32'(bus.o_ready), 32'd1);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_valid) seen = 1'b1;
        end
        chk("flush.no_valid", 32'(seen), 32'd0);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_data = 32'd9;
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;
        chk("flush.beats_valid", 32'(bus.o_ready), 32'd1);
        do_sample("flush_imp0", 0, 32'd1000, 32'd1000, 1'b0, 0, 0, 32'd0);
        do_sample("flush_imp1", 0, 32'd0, 32'd500, 1'b0, 0, 0, 32'd0);

        // Asynchronous reset mid-MAC restores outputs and passthrough coefficients.
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_ch = '0; bus.i_data = 32'd5;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid.o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_mid.o_ready", 32'(bus.o_ready), 32'd1);
        chk("rst_mid.o_data",  bus.o_data,       32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_sample("rst_pass0", 0, 32'd777, 32'd777, 1'b0, 0, 0, 32'd0);
        do_sample("rst_pass1", 1, 32'd1000, 32'd1000, 1'b0, 0, 0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
